// File: rtl/if_front_end.sv
`default_nettype none
// ============================================================================
// Module   : if_front_end
// Brief    : Instruction-fetch front end: PC register, IF/ID pipeline register,
//            next-PC selection, stall/flush/redirect handling, event counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_front_end #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_PC_Write,
    input  logic        IF_ID_Write,
    input  logic        IF_ID_Flush,
    input  logic [2:0]  ID_PCSrc,
    input  logic [25:0] ID_JT,
    input  logic [31:0] ID_DataBusA,
    input  logic [2:0]  EX_PCSrc,
    input  logic        EX_ALUOut0,
    input  logic [31:0] EX_BranchTarget,
    input  logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC_Plus4,
    output logic [31:0] ID_Instruction,
    output logic        ID_Valid,
    output logic [15:0] Stall_Count,
    output logic [15:0] Flush_Count
);

    localparam logic [2:0]  c_PCSRC_BRANCH = 3'b001;
    localparam logic [2:0]  c_PCSRC_JUMP   = 3'b010;
    localparam logic [2:0]  c_PCSRC_JREG   = 3'b011;
    localparam logic [2:0]  c_PCSRC_INTR   = 3'b100;
    localparam logic [2:0]  c_PCSRC_EXCP   = 3'b101;
    localparam logic [15:0] c_COUNT_MAX    = 16'hFFFF;

    logic        w_br;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;
    logic        w_pc_load;
    logic        w_id_bubble;
    logic        w_id_load;
    logic        w_stall_evt;

    logic [31:0] r_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_id_instruction;
    logic        r_id_valid;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    assign w_br          = (EX_PCSrc == c_PCSRC_BRANCH) && EX_ALUOut0;
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_jump_target = {r_id_pc_plus4[31:28], ID_JT, 2'b00};

    // A taken branch in EX is older than anything in ID, so it wins outright.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_br) begin
            w_next_pc = EX_BranchTarget;
        end else begin
            case (ID_PCSrc)
                c_PCSRC_EXCP: w_next_pc = XADR_PC;
                c_PCSRC_INTR: w_next_pc = ILLOP_PC;
                c_PCSRC_JREG: w_next_pc = ID_DataBusA;
                c_PCSRC_JUMP: w_next_pc = w_jump_target;
                default:      w_next_pc = w_pc_plus4;
            endcase
        end
    end

    // The instruction held in ID is on the wrong path once a branch resolves,
    // so the branch must be allowed to move the PC even through a stall.
    assign w_pc_load   = IF_PC_Write || w_br;
    assign w_stall_evt = !IF_PC_Write && !w_br;

    // Hold takes precedence over flush so a stalled jr is not lost.
    always_comb begin
        w_id_bubble = 1'b0;
        w_id_load   = 1'b0;
        if (w_br) begin
            w_id_bubble = 1'b1;
        end else if (!IF_ID_Write) begin
            w_id_bubble = 1'b0;
        end else if (IF_ID_Flush) begin
            w_id_bubble = 1'b1;
        end else begin
            w_id_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_pc_plus4    <= 32'h0;
            r_id_instruction <= 32'h0;
            r_id_valid       <= 1'b0;
        end else if (w_id_bubble) begin
            r_id_pc_plus4    <= 32'h0;
            r_id_instruction <= 32'h0;
            r_id_valid       <= 1'b0;
        end else if (w_id_load) begin
            r_id_pc_plus4    <= w_pc_plus4;
            r_id_instruction <= IF_Instruction;
            r_id_valid       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'h0;
            r_flush_count <= 16'h0;
        end else begin
            if (w_stall_evt && (r_stall_count != c_COUNT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_id_bubble && (r_flush_count != c_COUNT_MAX)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign IF_PC          = r_pc;
    assign ID_PC_Plus4    = r_id_pc_plus4;
    assign ID_Instruction = r_id_instruction;
    assign ID_Valid       = r_id_valid;
    assign Stall_Count    = r_stall_count;
    assign Flush_Count    = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_if_front_end.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_front_end
// Brief    : Self-checking bench for if_front_end (vector table, corner
//            sequences, randomized run against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_front_end;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_PC_Write, IF_ID_Write, IF_ID_Flush;
    logic [2:0]  ID_PCSrc;
    logic [25:0] ID_JT;
    logic [31:0] ID_DataBusA;
    logic [2:0]  EX_PCSrc;
    logic        EX_ALUOut0;
    logic [31:0] EX_BranchTarget;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC, ID_PC_Plus4, ID_Instruction;
    logic        ID_Valid;
    logic [15:0] Stall_Count, Flush_Count;

    always #5 clk = ~clk;

    if_front_end dut (
        .clk             (clk),
        .reset           (reset),
        .IF_PC_Write     (IF_PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_PCSrc        (ID_PCSrc),
        .ID_JT           (ID_JT),
        .ID_DataBusA     (ID_DataBusA),
        .EX_PCSrc        (EX_PCSrc),
        .EX_ALUOut0      (EX_ALUOut0),
        .EX_BranchTarget (EX_BranchTarget),
        .IF_Instruction  (IF_Instruction),
        .IF_PC           (IF_PC),
        .ID_PC_Plus4     (ID_PC_Plus4),
        .ID_Instruction  (ID_Instruction),
        .ID_Valid        (ID_Valid),
        .Stall_Count     (Stall_Count),
        .Flush_Count     (Flush_Count)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        pcw, idw, fl;
        logic [2:0]  id_src;
        logic [25:0] jt;
        logic [31:0] busa;
        logic [2:0]  ex_src;
        logic        alu0;
        logic [31:0] brt, inst;
        logic [31:0] e_pc, e_pc4, e_inst;
        logic        e_valid;
        logic [15:0] e_stall, e_flush;
    } vec_t;

    vec_t vt[15];

    // Reference model state
    logic [31:0] m_pc, m_pc4, m_inst;
    logic        m_valid;
    int          m_stall, m_flush;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                             input logic [31:0] inst, input logic valid,
                             input logic [15:0] st, input logic [15:0] fc);
        chk({tag, ".IF_PC"}, IF_PC, pc);
        chk({tag, ".ID_PC_Plus4"}, ID_PC_Plus4, pc4);
        chk({tag, ".ID_Instruction"}, ID_Instruction, inst);
        chk({tag, ".ID_Valid"}, {31'h0, ID_Valid}, {31'h0, valid});
        chk({tag, ".Stall_Count"}, {16'h0, Stall_Count}, {16'h0, st});
        chk({tag, ".Flush_Count"}, {16'h0, Flush_Count}, {16'h0, fc});
    endtask

    task automatic drive(input logic pcw, input logic idw, input logic fl, input logic [2:0] id_src,
                         input logic [25:0] jt, input logic [31:0] busa, input logic [2:0] ex_src,
                         input logic alu0, input logic [31:0] brt, input logic [31:0] inst);
        IF_PC_Write = pcw; IF_ID_Write = idw; IF_ID_Flush = fl;
        ID_PCSrc = id_src; ID_JT = jt; ID_DataBusA = busa;
        EX_PCSrc = ex_src; EX_ALUOut0 = alu0; EX_BranchTarget = brt;
        IF_Instruction = inst;
    endtask

    // Behavioural rules applied to the current inputs, giving the state after the edge.
    task automatic model_update();
        logic        br;
        logic [31:0] seq, target;
        if (reset) begin
            m_pc = 32'h8000_0000; m_pc4 = 0; m_inst = 0; m_valid = 0;
            m_stall = 0; m_flush = 0;
            return;
        end
        br  = (EX_PCSrc == 3'b001) && EX_ALUOut0;
        seq = m_pc + 32'd4;
        if (br)                     target = EX_BranchTarget;
        else if (ID_PCSrc == 3'd5)  target = 32'h8000_0008;
        else if (ID_PCSrc == 3'd4)  target = 32'h8000_0004;
        else if (ID_PCSrc == 3'd3)  target = ID_DataBusA;
        else if (ID_PCSrc == 3'd2)  target = {m_pc4[31:28], ID_JT, 2'b00};
        else                        target = seq;
        if (!IF_PC_Write && !br) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (br || (IF_ID_Write && IF_ID_Flush)) begin
            m_inst = 0; m_pc4 = 0; m_valid = 0;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (IF_ID_Write) begin
            m_inst = IF_Instruction; m_pc4 = seq; m_valid = 1;
        end
        if (IF_PC_Write || br) m_pc = target;
    endtask

    initial begin
        vt[0]  = '{1'b1,1'b1,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hA1,
                   32'h8000_0004,32'h8000_0004,32'hA1,1'b1,16'd0,16'd0};
        vt[1]  = '{1'b1,1'b1,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hA2,
                   32'h8000_0008,32'h8000_0008,32'hA2,1'b1,16'd0,16'd0};
        vt[2]  = '{1'b0,1'b0,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hA3,
                   32'h8000_0008,32'h8000_0008,32'hA2,1'b1,16'd1,16'd0};
        vt[3]  = '{1'b1,1'b1,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hA3,
                   32'h8000_000C,32'h8000_000C,32'hA3,1'b1,16'd1,16'd0};
        vt[4]  = '{1'b1,1'b1,1'b1,3'b010,26'h40,32'h0,3'b000,1'b0,32'h0,32'hA4,
                   32'h8000_0100,32'h0,32'h0,1'b0,16'd1,16'd1};
        vt[5]  = '{1'b1,1'b1,1'b1,3'b011,26'h0,32'h100,3'b000,1'b0,32'h0,32'hA5,
                   32'h100,32'h0,32'h0,1'b0,16'd1,16'd2};
        vt[6]  = '{1'b1,1'b1,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hB1,
                   32'h104,32'h104,32'hB1,1'b1,16'd1,16'd2};
        vt[7]  = '{1'b0,1'b0,1'b1,3'b011,26'h0,32'h500,3'b000,1'b0,32'h0,32'hB2,
                   32'h104,32'h104,32'hB1,1'b1,16'd2,16'd2};
        vt[8]  = '{1'b0,1'b0,1'b0,3'b101,26'h0,32'h0,3'b001,1'b1,32'h200,32'hB2,
                   32'h200,32'h0,32'h0,1'b0,16'd2,16'd3};
        vt[9]  = '{1'b1,1'b1,1'b1,3'b101,26'h0,32'h0,3'b001,1'b0,32'h300,32'hB3,
                   32'h8000_0008,32'h0,32'h0,1'b0,16'd2,16'd4};
        vt[10] = '{1'b1,1'b1,1'b0,3'b100,26'h0,32'h0,3'b000,1'b0,32'h0,32'hC1,
                   32'h8000_0004,32'h8000_000C,32'hC1,1'b1,16'd2,16'd4};
        vt[11] = '{1'b1,1'b1,1'b0,3'b001,26'h0,32'h0,3'b010,1'b1,32'h700,32'hC2,
                   32'h8000_0008,32'h8000_0008,32'hC2,1'b1,16'd2,16'd4};
        vt[12] = '{1'b1,1'b1,1'b0,3'b110,26'h0,32'h0,3'b000,1'b0,32'h0,32'hC3,
                   32'h8000_000C,32'h8000_000C,32'hC3,1'b1,16'd2,16'd4};
        vt[13] = '{1'b1,1'b0,1'b1,3'b111,26'h0,32'h0,3'b000,1'b0,32'h0,32'hC9,
                   32'h8000_0010,32'h8000_000C,32'hC3,1'b1,16'd2,16'd4};
        vt[14] = '{1'b0,1'b1,1'b0,3'b000,26'h0,32'h0,3'b000,1'b0,32'h0,32'hC4,
                   32'h8000_0010,32'h8000_0014,32'hC4,1'b1,16'd3,16'd4};

        // Reset with hostile inputs (taken branch, stall, flush) held for two cycles
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 3'b101, 26'h3FF, 32'h1234, 3'b001, 1'b1, 32'h400, 32'hDEAD);
        step();
        check_all("reset1", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        step();
        check_all("reset2", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].pcw, vt[i].idw, vt[i].fl, vt[i].id_src, vt[i].jt, vt[i].busa,
                  vt[i].ex_src, vt[i].alu0, vt[i].brt, vt[i].inst);
            step();
            check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_pc4, vt[i].e_inst,
                      vt[i].e_valid, vt[i].e_stall, vt[i].e_flush);
        end

        // PC wrap-around at the top of the address space
        drive(1'b1, 1'b1, 1'b1, 3'b011, 26'h0, 32'hFFFF_FFFC, 3'b000, 1'b0, 32'h0, 32'hD0);
        step();
        check_all("wrap_jr", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd3, 16'd5);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 26'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'hD1);
        step();
        check_all("wrap_seq", 32'h0, 32'h0, 32'hD1, 1'b1, 16'd3, 16'd5);

        // Mid-stream reset while a branch is taken; first fetch is RESET_PC
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 3'b010, 26'h55, 32'h0, 3'b001, 1'b1, 32'h900, 32'hE0);
        step();
        check_all("midreset", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 26'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'hE1);
        step();
        check_all("postreset", 32'h8000_0004, 32'h8000_0004, 32'hE1, 1'b1, 16'd0, 16'd0);

        // Randomized run against the reference model
        reset = 1'b1;
        model_update();
        step();
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            reset          = ($urandom_range(63) == 0);
            IF_PC_Write    = ($urandom_range(3) != 0);
            IF_ID_Write    = ($urandom_range(3) != 0);
            IF_ID_Flush    = ($urandom_range(3) == 0);
            ID_PCSrc       = 3'($urandom_range(7));
            ID_JT          = 26'($urandom);
            ID_DataBusA    = $urandom & 32'hFFFF_FFFC;
            EX_PCSrc       = ($urandom_range(3) == 0) ? 3'b001 : 3'($urandom_range(7));
            EX_ALUOut0     = 1'($urandom_range(1));
            EX_BranchTarget = $urandom & 32'hFFFF_FFFC;
            IF_Instruction = $urandom;
            model_update();
            step();
            check_all($sformatf("rand%0d", i), m_pc, m_pc4, m_inst, m_valid,
                      16'(m_stall), 16'(m_flush));
        end
        reset = 1'b0;

        // Counter saturation: continuous stall with flush
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 26'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 3'b000, 26'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'hF0);
        for (int i = 0; i < 65534; i++) step();
        check_all("sat_m1", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'hFFFE, 16'hFFFE);
        step();
        check_all("sat_hit", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) step();
        check_all("sat_hold", 32'h8000_0000, 32'h0, 32'h0, 1'b0, 16'hFFFF, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_front_end.md
# if_front_end

Instruction-fetch front end of the five-stage pipeline: holds the PC register and the IF/ID pipeline register, and applies the stall, flush and redirect controls produced by the hazard unit. It selects the next PC from sequential, jump, jump-register, branch, interrupt and exception sources, and inserts bubbles into ID. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ILLOP_PC, 32'h8000_0004, interrupt vector.
- XADR_PC, 32'h8000_0008, exception vector.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- IF_PC_Write  in  1  1 = PC may advance; 0 = stall PC.
- IF_ID_Write  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- IF_ID_Flush  in  1  1 = load a bubble into IF/ID.
- ID_PCSrc  in  3  PC source decoded in ID: 000 seq, 010 j/jal, 011 jr/jalr, 100 interrupt, 101 exception.
- ID_JT  in  26  jump index field of the ID instruction.
- ID_DataBusA  in  32  forwarded rs value for jr/jalr.
- EX_PCSrc  in  3  PC source of the EX instruction; 001 = branch.
- EX_ALUOut0  in  1  branch condition true.
- EX_BranchTarget  in  32  branch target computed in EX.
- IF_Instruction  in  32  instruction memory read data at IF_PC.
- IF_PC  out  32  current fetch address.
- ID_PC_Plus4  out  32  PC+4 of the instruction in ID.
- ID_Instruction  out  32  instruction in ID; 32'h0 (nop) when bubble.
- ID_Valid  out  1  1 = ID holds a real instruction.
- Stall_Count  out  16  saturating count of PC-stall cycles.
- Flush_Count  out  16  saturating count of IF/ID flush cycles.

## Operation
- Branch taken: br = (EX_PCSrc == 001) & EX_ALUOut0.
- PC_Plus4 = IF_PC + 4, 32-bit wrap-around; no carry out.
- Jump target JT = {ID_PC_Plus4[31:28], ID_JT, 2'b00}.
- Next-PC priority, highest first:
  - br: EX_BranchTarget.
  - ID_PCSrc 101: XADR_PC.
  - ID_PCSrc 100: ILLOP_PC.
  - ID_PCSrc 011: ID_DataBusA.
  - ID_PCSrc 010: JT.
  - otherwise: PC_Plus4. Codes 001, 110 and 111 in ID_PCSrc are treated as sequential.
- PC update: load next-PC when IF_PC_Write=1 or br=1. br overrides a stall, because the stalled ID instruction is on the wrong path. Otherwise hold.
- IF/ID update, priority highest first:
  - br=1: bubble (ID_Instruction=0, ID_PC_Plus4=0, ID_Valid=0).
  - IF_ID_Write=0: hold all IF/ID fields, even if IF_ID_Flush=1. A stalled jr in ID must not be killed.
  - IF_ID_Flush=1: bubble.
  - otherwise: load IF_Instruction, PC_Plus4, ID_Valid=1.
- Jump redirect when IF_PC_Write=0 (jr waiting on a load): PC holds. The jump re-evaluates next cycle with forwarded data.
- Stall_Count: increments on any cycle with IF_PC_Write=0 and br=0. Saturates at 16'hFFFF.
- Flush_Count: increments on any cycle where IF/ID loads a bubble. Saturates at 16'hFFFF.

## Timing
- Reset, sampled at a clock edge, sets IF_PC=RESET_PC, ID_Instruction=0, ID_PC_Plus4=0, ID_Valid=0, and both counters to 0. Reset overrides all other inputs.
- Deassertion of reset mid-stream: the first fetch is RESET_PC on the cycle after reset drops.
- Redirect latency:
  - Jump in ID: target appears on IF_PC one cycle later; one bubble.
  - Taken branch in EX: target appears on IF_PC one cycle later; the IF/ID instruction is flushed. Flushing ID/EX is the hazard unit's job.
- All outputs are registered. IF_Instruction is sampled combinationally at the edge; there is no internal memory latency.

## Test plan
- Reset: assert reset 2 cycles → IF_PC=32'h8000_0000, ID_Valid=0, ID_Instruction=0, counters=0. Release reset → IF_PC steps to 8000_0004, then 8000_0008; ID_PC_Plus4 trails by one cycle.
- Load-use stall: IF_PC=0x100, IF_PC_Write=0, IF_ID_Write=0 for 1 cycle → IF_PC stays 0x100, ID fields hold, Stall_Count=1. Resume → IF_PC=0x104.
- Jump: ID_PCSrc=010, ID_JT=26'h40, ID_PC_Plus4=0x0000_0104, IF_ID_Flush=1 → next IF_PC=0x0000_0100, ID_Valid=0, Flush_Count increments.
- Branch over stall: IF_PC_Write=0, IF_ID_Write=0, EX_PCSrc=001, EX_ALUOut0=1, EX_BranchTarget=0x200 → IF_PC=0x200, ID bubble, Stall_Count unchanged.
- Branch beats exception: br=1 with ID_PCSrc=101 → IF_PC=EX_BranchTarget. Stalled jr with IF_ID_Flush=1 and IF_ID_Write=0 → ID holds the jr, PC holds.
- Saturation and wrap: force 65536+ stall cycles → Stall_Count stays 16'hFFFF. IF_PC=32'hFFFF_FFFC sequential → IF_PC=0.
